// File: rtl/eth_rx_addr_filter.sv
// Destination-MAC filter for the 8-bit RGMII RX stream: buffers the 6-byte
// destination field, replays it for accepted frames and swallows the rest.
module eth_rx_addr_filter (
  input  logic        clock125,
  input  logic        reset,
  input  logic [47:0] mac_addr,
  input  logic        promiscuous,
  input  logic        accept_multicast,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] frames_passed,
  output logic [31:0] frames_dropped
);

  typedef enum logic [1:0] {HDR, REPLAY, STREAM, DROP} state_t;

  state_t      state_reg;
  logic [2:0]  index_reg;
  logic [31:0] passed_reg;
  logic [31:0] dropped_reg;

  logic        s_fire;
  logic        m_fire;
  logic        addr_match;
  logic [47:0] hdr_flat;
  logic [47:0] dest;
  logic [7:0]  replay_byte;

  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;

  // One capture register per header byte; byte 0 lands in the top octet so
  // hdr_flat reads in wire order like mac_addr.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hdr
      logic [7:0] byte_reg;

      always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
          byte_reg <= '0;
        end else if (state_reg == HDR && s_fire && index_reg == 3'(gi)) begin
          byte_reg <= s_axis_tdata;
        end
      end

      assign hdr_flat[47-8*gi -: 8] = byte_reg;
    end
  endgenerate

  // The sixth byte is still on the bus in the decision cycle.
  assign dest = {hdr_flat[47:8], s_axis_tdata};

  assign addr_match = promiscuous
                   || (dest == mac_addr)
                   || (dest == 48'hFFFF_FFFF_FFFF)
                   || (accept_multicast && hdr_flat[40]);

  always_comb begin
    replay_byte = hdr_flat[47:40];
    case (index_reg)
      3'd1:    replay_byte = hdr_flat[39:32];
      3'd2:    replay_byte = hdr_flat[31:24];
      3'd3:    replay_byte = hdr_flat[23:16];
      3'd4:    replay_byte = hdr_flat[15:8];
      3'd5:    replay_byte = hdr_flat[7:0];
      default: replay_byte = hdr_flat[47:40];
    endcase
  end

  // Outputs are forced low while reset is held, including the ready.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    if (!reset) begin
      case (state_reg)
        HDR, DROP: s_axis_tready = 1'b1;
        REPLAY: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = replay_byte;
        end
        STREAM: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = s_axis_tuser;
        end
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      state_reg   <= HDR;
      index_reg   <= 3'd0;
      passed_reg  <= 32'd0;
      dropped_reg <= 32'd0;
    end else begin
      case (state_reg)
        HDR: begin
          if (s_fire) begin
            if (s_axis_tlast) begin
              dropped_reg <= dropped_reg + 32'd1;
              index_reg   <= 3'd0;
            end else if (index_reg == 3'd5) begin
              index_reg <= 3'd0;
              state_reg <= addr_match ? REPLAY : DROP;
            end else begin
              index_reg <= index_reg + 3'd1;
            end
          end
        end
        REPLAY: begin
          if (m_fire) begin
            if (index_reg == 3'd5) begin
              index_reg <= 3'd0;
              state_reg <= STREAM;
            end else begin
              index_reg <= index_reg + 3'd1;
            end
          end
        end
        STREAM: begin
          if (m_fire && m_axis_tlast) begin
            passed_reg <= passed_reg + 32'd1;
            state_reg  <= HDR;
          end
        end
        DROP: begin
          if (s_fire && s_axis_tlast) begin
            dropped_reg <= dropped_reg + 32'd1;
            state_reg   <= HDR;
          end
        end
        default: state_reg <= HDR;
      endcase
    end
  end

  assign frames_passed  = passed_reg;
  assign frames_dropped = dropped_reg;

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Bench for eth_rx_addr_filter: address-rule vectors, back-to-back and reset
// sequences, and randomized traffic against a frame-level scoreboard.
module tb_eth_rx_addr_filter;

  logic        clock125 = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] mac_addr = '0;
  logic        promiscuous = 1'b0;
  logic        accept_multicast = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [31:0] frames_passed;
  logic [31:0] frames_dropped;

  always #4 clock125 = ~clock125;

  eth_rx_addr_filter dut (
    .clock125         (clock125),
    .reset            (reset),
    .mac_addr         (mac_addr),
    .promiscuous      (promiscuous),
    .accept_multicast (accept_multicast),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frames_passed    (frames_passed),
    .frames_dropped   (frames_dropped)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    logic [47:0] mac;
    logic [47:0] dest;
    bit          prom;
    bit          mc;
    int          len;
    bit          user;
    bit          exp_pass;
    bit          chk_lat;
    bit          chk_rdy;
  } vec_t;

  localparam logic [47:0] M  = 48'h000A_3501_0203;
  localparam logic [47:0] N  = 48'h1122_3344_5566;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
  localparam int NV = 16;

  beat_t src_q[$];
  beat_t exp_q[$];
  vec_t  vecs[NV];

  int n_cmp = 0;
  int n_fail = 0;
  int exp_passed = 0;
  int exp_dropped = 0;
  int in_beats = 0;
  int out_beats = 0;
  int hdr_cyc = -1;
  int first_out_cyc = -1;
  int frames_out = 0;
  int rdy_pct = 100;
  int gap_pct = 0;
  bit rdy_always = 1'b0;
  bit in_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acceptance rule stated directly on the 48-bit destination.
  function automatic bit model_pass(input logic [47:0] mac, input logic [47:0] dest,
                                    input bit prom, input bit mc, input int len);
    bit hit;
    hit = prom || (dest == mac) || (dest == BC) || (mc && dest[40]);
    return (len >= 7) && hit;
  endfunction

  function automatic vec_t mk(input logic [47:0] mac, input logic [47:0] dest, input bit prom,
                              input bit mc, input int len, input bit user, input bit pass,
                              input bit lat, input bit rdy);
    vec_t v;
    v.mac = mac; v.dest = dest; v.prom = prom; v.mc = mc; v.len = len;
    v.user = user; v.exp_pass = pass; v.chk_lat = lat; v.chk_rdy = rdy;
    return v;
  endfunction

  task automatic enqueue_frame(input logic [47:0] dest, input int len, input bit user, input bit pass);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (i < 6) ? dest[47-8*i -: 8] : 8'($urandom);
      b.last = (i == len - 1);
      b.user = user && (i == len - 1);
      src_q.push_back(b);
      if (pass) exp_q.push_back(b);
    end
    if (pass) exp_passed++;
    else exp_dropped++;
  endtask

  // Inputs change on the falling edge; handshakes are judged 1 ns later,
  // so they describe what the next rising edge will commit.
  task automatic run(input int max_cycles, input int stop_in);
    int    cyc;
    bit    prev_stall;
    bit    done;
    beat_t prev_b;
    beat_t cur_b;
    beat_t e;
    cyc = 0; prev_stall = 1'b0; done = 1'b0; prev_b = '0;
    while (!done) begin
      @(negedge clock125);
      if (in_acc) begin
        s_axis_tvalid = 1'b0;
        in_acc = 1'b0;
      end
      if (!s_axis_tvalid && src_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        e = src_q.pop_front();
        s_axis_tdata = e.data; s_axis_tlast = e.last; s_axis_tuser = e.user;
        s_axis_tvalid = 1'b1;
      end
      m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      cur_b = '{m_axis_tdata, m_axis_tlast, m_axis_tuser};
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_beat", 64'(cur_b), 64'(prev_b));
      end
      if (rdy_always) chk("runt_tready", 64'(s_axis_tready), 64'd1);
      if (s_axis_tvalid && s_axis_tready) begin
        in_acc = 1'b1;
        in_beats++;
        if (in_beats == 6) hdr_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (out_beats == 1) first_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL out_beat_extra: got %0h expected no beat", cur_b);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'(cur_b), 64'(e));
          if (e.last) begin
            frames_out++;
            $display("frame %0d forwarded, tuser=%0d", frames_out, m_axis_tuser);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b = cur_b;
      cyc++;
      if (stop_in >= 0 && in_beats >= stop_in) done = 1'b1;
      else if (src_q.size() == 0 && (!s_axis_tvalid || in_acc) && exp_q.size() == 0) done = 1'b1;
      else if (cyc >= max_cycles) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: got %0d beats pending expected 0 after %0d cycles",
                 exp_q.size(), cyc);
        done = 1'b1;
      end
    end
    @(negedge clock125);
    if (in_acc) begin
      s_axis_tvalid = 1'b0;
      in_acc = 1'b0;
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_passed"}, 64'(frames_passed), 64'(exp_passed));
    chk({tag, "_dropped"}, 64'(frames_dropped), 64'(exp_dropped));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish expected finish before 1.5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t       e;
    logic [47:0] d;
    int          len;
    int          k;
    bit          pass;

    vecs[0]  = mk(M, M,                  1'b0, 1'b0, 64,  1'b0, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(M, 48'h000A_3501_0204, 1'b0, 1'b0, 64,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(M, BC,                 1'b0, 1'b0, 64,  1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(M, 48'h0100_5E00_0001, 1'b0, 1'b0, 64,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(M, 48'h0100_5E00_0001, 1'b0, 1'b1, 64,  1'b0, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(M, 48'h1234_5678_9ABC, 1'b1, 1'b0, 64,  1'b0, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(M, M,                  1'b0, 1'b0, 4,   1'b0, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(M, M,                  1'b0, 1'b0, 6,   1'b0, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(M, M,                  1'b0, 1'b0, 7,   1'b0, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(M, 48'h0200_5E00_0001, 1'b0, 1'b1, 64,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(N, N,                  1'b0, 1'b0, 20,  1'b0, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(N, 48'h1022_3344_5566, 1'b0, 1'b1, 20,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(N, 48'h1122_3344_5567, 1'b0, 1'b0, 20,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(N, BC,                 1'b0, 1'b0, 300, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(M, 48'h1234_5678_9ABC, 1'b1, 1'b0, 5,   1'b0, 1'b0, 1'b0, 1'b1);
    vecs[15] = mk(M, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0, 30,  1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, then the first cycle after release.
    #2;
    chk("reset_outputs", 64'({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'd0);
    chk_counters("reset");
    repeat (3) @(negedge clock125);
    reset = 1'b0;
    #1;
    chk("release_tready", 64'(s_axis_tready), 64'd1);
    chk("release_tvalid", 64'(m_axis_tvalid), 64'd0);

    for (int v = 0; v < NV; v++) begin
      mac_addr = vecs[v].mac; promiscuous = vecs[v].prom; accept_multicast = vecs[v].mc;
      rdy_pct = 100; gap_pct = 0; rdy_always = vecs[v].chk_rdy;
      in_beats = 0; out_beats = 0; hdr_cyc = -1; first_out_cyc = -1;
      enqueue_frame(vecs[v].dest, vecs[v].len, vecs[v].user, vecs[v].exp_pass);
      run(5000, -1);
      rdy_always = 1'b0;
      chk_counters("vec");
      chk("vec_out_beats", 64'(out_beats), vecs[v].exp_pass ? 64'(vecs[v].len) : 64'd0);
      if (vecs[v].chk_lat) chk("hdr_latency", 64'(first_out_cyc - hdr_cyc), 64'd1);
      $display("vec %0d dest=%012h len=%0d out_beats=%0d passed=%0d dropped=%0d",
               v, vecs[v].dest, vecs[v].len, out_beats, frames_passed, frames_dropped);
    end

    // Miss followed back-to-back by broadcast.
    mac_addr = M; promiscuous = 1'b0; accept_multicast = 1'b0;
    out_beats = 0;
    enqueue_frame(48'h000A_3501_0204, 64, 1'b0, 1'b0);
    enqueue_frame(BC, 64, 1'b0, 1'b1);
    run(5000, -1);
    chk_counters("b2b");
    chk("b2b_out_beats", 64'(out_beats), 64'd64);
    $display("b2b miss+broadcast: passed=%0d dropped=%0d", frames_passed, frames_dropped);

    // 100 matching frames under 30% output ready.
    mac_addr = M; promiscuous = 1'b0; accept_multicast = 1'b1;
    rdy_pct = 30; gap_pct = 0;
    k = frames_out;
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(2))
        0:       d = M;
        1:       d = BC;
        default: d = {8'($urandom) | 8'h01, 8'($urandom), 32'($urandom)};
      endcase
      len = (i % 25 == 0) ? 1514 : int'($urandom_range(120, 60));
      enqueue_frame(d, len, (i % 7 == 6), model_pass(mac_addr, d, 1'b0, 1'b1, len));
    end
    run(90000, -1);
    chk_counters("bp");
    chk("bp_frames_out", 64'(frames_out - k), 64'd100);
    $display("backpressure phase: passed=%0d dropped=%0d", frames_passed, frames_dropped);

    // Mixed random traffic with random filter settings per frame.
    rdy_pct = 70; gap_pct = 20;
    for (int i = 0; i < 40; i++) begin
      mac_addr = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      promiscuous = ($urandom_range(9) == 0);
      accept_multicast = 1'($urandom);
      case ($urandom_range(4))
        0:       d = mac_addr;
        1:       d = BC;
        2:       d = {8'($urandom) | 8'h01, 8'($urandom), 32'($urandom)};
        3:       d = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
        default: d = mac_addr ^ (48'd1 << $urandom_range(47));
      endcase
      len = int'($urandom_range(40, 1));
      pass = model_pass(mac_addr, d, promiscuous, accept_multicast, len);
      enqueue_frame(d, len, 1'($urandom), pass);
      run(3000, -1);
      chk_counters("mix");
      $display("mix %0d dest=%012h len=%0d expect_pass=%0d", i, d, len, pass);
    end

    // Reset asserted while frame 3 is streaming.
    mac_addr = M; promiscuous = 1'b0; accept_multicast = 1'b0;
    rdy_pct = 100; gap_pct = 0;
    enqueue_frame(M, 80, 1'b0, 1'b1);
    enqueue_frame(M, 80, 1'b0, 1'b1);
    run(2000, -1);
    in_beats = 0;
    enqueue_frame(M, 100, 1'b0, 1'b1);
    run(2000, 30);
    e = src_q.pop_front();
    s_axis_tdata = e.data; s_axis_tlast = e.last; s_axis_tuser = e.user; s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    chk("stream_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("stream_tdata", 64'(m_axis_tdata), 64'(e.data));
    reset = 1'b1;
    #1;
    chk("midreset_outputs", 64'({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'd0);
    exp_passed = 0; exp_dropped = 0;
    chk_counters("midreset");
    src_q.delete(); exp_q.delete();
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge clock125);
    @(negedge clock125);
    reset = 1'b0;
    #1;
    chk("midreset_release_tready", 64'(s_axis_tready), 64'd1);
    enqueue_frame(BC, 20, 1'b0, 1'b1);
    run(2000, -1);
    chk_counters("post_reset");
    $display("mid-stream reset: passed=%0d dropped=%0d", frames_passed, frames_dropped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
